// File: rtl/bank_responder_pkg.sv
// bank_responder_pkg: shared widths, payload/response layouts and width helpers
package bank_responder_pkg;
   localparam int NUM_IN = 4;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   function automatic int ini_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int be_w(input int dw);
      return dw / 8;
   endfunction
   function automatic int req_w(input int aw, input int dw);
      return 1 + dw / 8 + aw + dw;
   endfunction
   localparam int INI_W = ini_w(NUM_IN);
   typedef struct packed {
      logic                wen;
      logic [DATA_W/8-1:0] be;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   wdata;
   } req_payload_t;
   typedef struct packed {
      logic [INI_W-1:0]  ini_addr;
      logic [DATA_W-1:0] rdata;
   } resp_entry_t;
endpackage

// File: rtl/bank_responder_if.sv
// bank_responder_if: crossbar target request/response port between initiator side and bank
interface bank_responder_if import bank_responder_pkg::*; #(
   parameter int IniW         = INI_W,
   parameter int ReqDataWidth = req_w(ADDR_W, DATA_W),
   parameter int DataWidth    = DATA_W
);
   logic                    req_valid_i;
   logic                    req_ready_o;
   logic [IniW-1:0]         req_ini_addr_i;
   logic [ReqDataWidth-1:0] req_wdata_i;
   logic                    resp_valid_o;
   logic                    resp_ready_i;
   logic [IniW-1:0]         resp_ini_addr_o;
   logic [DataWidth-1:0]    resp_rdata_o;
   modport master (
      output req_valid_i, req_ini_addr_i, req_wdata_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_ini_addr_o, resp_rdata_o
   );
   modport slave (
      input  req_valid_i, req_ini_addr_i, req_wdata_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_ini_addr_o, resp_rdata_o
   );
endinterface

// File: rtl/bank_resp_fifo.sv
// bank_resp_fifo: non-fall-through response buffer with async reset and full/empty/count
module bank_resp_fifo #(
   parameter int Width = 34,
   parameter int Depth = 3,
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_push,
   input  logic [Width-1:0] i_data,
   input  logic             i_pop,
   output logic [Width-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CntW-1:0]  o_count
);
   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wr, r_rd;
   logic [CntW-1:0]  r_cnt;
   logic             w_push, w_pop;
   function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction
   assign o_full  = r_cnt == CntW'(Depth);
   assign o_empty = r_cnt == '0;
   assign o_count = r_cnt;
   assign o_data  = o_empty ? '0 : r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
         for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= inc(r_wr);
         end
         if (w_pop) r_rd <= inc(r_rd);
         r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
      end
   end
endmodule

// File: rtl/bank_responder.sv
// bank_responder: crossbar target endpoint driving a fixed-latency SRAM bank with credit-bounded responses.
// Define BANK_RESPONDER_WRITE_RESP_EN to return a response for every write; otherwise writes are posted.
module bank_responder import bank_responder_pkg::*; #(
   parameter int NumIn      = NUM_IN,
   parameter int AddrWidth  = ADDR_W,
   parameter int DataWidth  = DATA_W,
   parameter int MemLatency = 1,
   parameter int FifoDepth  = 3,
   localparam int IniW         = ini_w(NumIn),
   localparam int BeW          = be_w(DataWidth),
   localparam int ReqDataWidth = req_w(AddrWidth, DataWidth),
   localparam int CntW         = $clog2(FifoDepth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   bank_responder_if.slave      bus,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [BeW-1:0]       mem_be_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic [DataWidth-1:0] mem_rdata_i
);
   logic                  w_accept, w_wen, w_resp_acc, w_pop, w_push, w_full, w_empty;
   logic [CntW-1:0]       r_credit, w_count;
   logic [MemLatency-1:0] r_pv, r_pw;
   logic [IniW-1:0]       r_pt [MemLatency];
   logic [DataWidth-1:0]  w_rdata, w_head_rdata;
   logic [IniW-1:0]       w_head_ini;
   assign w_wen            = bus.req_wdata_i[ReqDataWidth-1];
   assign bus.req_ready_o  = !rst_i && (r_credit < CntW'(FifoDepth));
   assign w_accept         = bus.req_valid_i && bus.req_ready_o;
`ifdef BANK_RESPONDER_WRITE_RESP_EN
   assign w_resp_acc = w_accept;
`else
   assign w_resp_acc = w_accept && !w_wen;
`endif
   assign mem_req_o   = w_accept;
   assign mem_we_o    = w_wen;
   assign mem_be_o    = bus.req_wdata_i[DataWidth+AddrWidth +: BeW];
   assign mem_addr_o  = bus.req_wdata_i[DataWidth +: AddrWidth];
   assign mem_wdata_o = bus.req_wdata_i[DataWidth-1:0];
   assign w_pop       = bus.resp_valid_o && bus.resp_ready_i;
   // Credits cover buffered plus in-flight responses, so the FIFO can never overflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_credit <= '0;
      else       r_credit <= r_credit + CntW'(w_resp_acc) - CntW'(w_pop);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pv <= '0;
         r_pw <= '0;
         for (int i = 0; i < MemLatency; i++) r_pt[i] <= '0;
      end else begin
         r_pv[0] <= w_resp_acc;
         r_pw[0] <= w_wen;
         r_pt[0] <= bus.req_ini_addr_i;
         for (int i = 1; i < MemLatency; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pw[i] <= r_pw[i-1];
            r_pt[i] <= r_pt[i-1];
         end
      end
   end
   assign w_push  = r_pv[MemLatency-1];
   assign w_rdata = r_pw[MemLatency-1] ? '0 : mem_rdata_i;
   bank_resp_fifo #(.Width(IniW + DataWidth), .Depth(FifoDepth)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (w_push),
      .i_data  ({r_pt[MemLatency-1], w_rdata}),
      .i_pop   (w_pop),
      .o_data  ({w_head_ini, w_head_rdata}),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
   assign bus.resp_valid_o    = !w_empty;
   assign bus.resp_ini_addr_o = w_head_ini;
   assign bus.resp_rdata_o    = w_head_rdata;
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full));
   a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i) r_credit >= w_count);
endmodule

// File: tb/tb_bank_responder.sv
// tb_bank_responder: scoreboard bench for bank_responder with a behavioural SRAM
module tb_bank_responder;
   import bank_responder_pkg::*;
`ifdef BANK_RESPONDER_WRITE_RESP_EN
   localparam bit WR_RESP = 1'b1;
`else
   localparam bit WR_RESP = 1'b0;
`endif
   logic        clk = 0, rst = 1;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata = '0;
   logic [31:0] sram [1024];
   logic [31:0] exp_mem [1024];
   resp_entry_t sb [$];
   int          pop_cyc [$];
   int          cyc = 0, vectors = 0, miscompares = 0;

   bank_responder_if bus ();
   bank_responder dut (
      .clk_i(clk), .rst_i(rst), .bus(bus),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (mem_req) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else mem_rdata <= sram[mem_addr];
   end

   always begin
      resp_entry_t e;
      @(negedge clk); #4;
      if (!rst && bus.resp_valid_o && bus.resp_ready_i) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_resp: got tag=%0d rdata=%h, required none", bus.resp_ini_addr_o, bus.resp_rdata_o);
         end else begin
            e = sb.pop_front();
            if (bus.resp_ini_addr_o !== e.ini_addr || bus.resp_rdata_o !== e.rdata) begin
               miscompares++;
               $display("FAIL resp_scoreboard: got tag=%0d rdata=%h, required tag=%0d rdata=%h",
                        bus.resp_ini_addr_o, bus.resp_rdata_o, e.ini_addr, e.rdata);
            end
         end
         pop_cyc.push_back(cyc);
      end
   end

   task automatic send(input bit wen, input logic [3:0] be, input logic [9:0] addr, input logic [31:0] wd,
                       input logic [1:0] tag, output int stalls, output int acc_cyc);
      req_payload_t p;
      bit acc = 0;
      p = '{wen: wen, be: be, addr: addr, wdata: wd};
      bus.req_valid_i = 1; bus.req_wdata_i = p; bus.req_ini_addr_i = tag;
      stalls = 0; acc_cyc = -1;
      for (int n = 0; n < 50 && !acc; n++) begin
         #4;
         acc = bus.req_ready_o;
         if (acc) begin
            acc_cyc = cyc;
            if (!wen || WR_RESP) sb.push_back('{ini_addr: tag, rdata: wen ? 32'h0 : exp_mem[addr]});
            if (wen) for (int b = 0; b < 4; b++) if (be[b]) exp_mem[addr][8*b +: 8] = wd[8*b +: 8];
         end else stalls++;
         @(negedge clk);
      end
      bus.req_valid_i = 0;
      vectors++;
      if (!acc) begin
         miscompares++;
         $display("FAIL accept_timeout: addr %h never accepted, required acceptance within 50 cycles", addr);
      end
   endtask

   task automatic drain();
      bus.resp_ready_i = 1;
      for (int n = 0; n < 60 && (sb.size() != 0 || bus.resp_valid_o); n++) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_reset();
      bus.req_valid_i = 1; bus.req_wdata_i = '0; bus.req_ini_addr_i = 0; bus.resp_ready_i = 0;
      repeat (2) @(negedge clk);
      #4;
      vectors += 5;
      if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b required 0", bus.req_ready_o); end
      if (bus.resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b required 0", bus.resp_valid_o); end
      if (bus.resp_ini_addr_o !== 2'd0) begin miscompares++; $display("FAIL rst_tag: got %0d required 0", bus.resp_ini_addr_o); end
      if (bus.resp_rdata_o !== 32'd0) begin miscompares++; $display("FAIL rst_rdata: got %h required 0", bus.resp_rdata_o); end
      if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b required 0", mem_req); end
      bus.req_valid_i = 0;
      @(negedge clk); rst = 0;
      #4; vectors++;
      if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b required 1", bus.req_ready_o); end
      @(negedge clk);
   endtask

   task automatic test_read_after_write();
      int s, c;
      bus.resp_ready_i = 0;
      send(1, 4'hF, 10'h005, 32'hDEADBEEF, 2'd2, s, c);
      #4; vectors++;
      if (bus.resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL raw_wr_early: valid %b required 0", bus.resp_valid_o); end
      @(negedge clk); #4; vectors++;
      if (bus.resp_valid_o !== WR_RESP) begin miscompares++; $display("FAIL raw_wr_latency: valid %b required %b", bus.resp_valid_o, WR_RESP); end
      @(negedge clk);
      bus.resp_ready_i = 1;
      send(0, 4'h0, 10'h005, 32'h0, 2'd1, s, c);
      #4; vectors++;
      if (bus.resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL raw_rd_early: valid %b required 0", bus.resp_valid_o); end
      @(negedge clk); #4; vectors++;
      if (bus.resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL raw_rd_latency: valid %b required 1", bus.resp_valid_o); end
      @(negedge clk);
      drain();
   endtask

   task automatic test_stream();
      int s, c, tot = 0, first = 0;
      bus.resp_ready_i = 1;
      for (int i = 0; i < 8; i++) begin send(1, 4'hF, 10'h010 + 10'(i), 32'hA5000000 + i * 32'h111, 2'(i), s, c); tot += s; end
      drain();
      pop_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         send(0, 4'h0, 10'h010 + 10'(i), 32'h0, 2'(3 - i % 4), s, c);
         tot += s;
         if (i == 0) first = c;
      end
      drain();
      vectors += 3;
      if (tot != 0) begin miscompares++; $display("FAIL stream_stalls: got %0d stall cycles required 0", tot); end
      if (pop_cyc.size() != 8) begin miscompares++; $display("FAIL stream_count: got %0d responses required 8", pop_cyc.size()); end
      else begin
         if (pop_cyc[0] != first + 2) begin miscompares++; $display("FAIL stream_latency: first resp cycle %0d required %0d", pop_cyc[0], first + 2); end
         for (int i = 1; i < 8; i++) begin
            vectors++;
            if (pop_cyc[i] != pop_cyc[0] + i) begin miscompares++; $display("FAIL stream_gap: resp %0d at cycle %0d required %0d", i, pop_cyc[i], pop_cyc[0] + i); end
         end
      end
   endtask

   task automatic test_backpressure();
      int s, c, tot = 0, s4, a4, s5, a5, rel = 0;
      bus.resp_ready_i = 0;
      for (int i = 0; i < 3; i++) begin send(0, 4'h0, 10'h011 + 10'(i), 32'h0, 2'(i), s, c); tot += s; end
      vectors++;
      if (tot != 0) begin miscompares++; $display("FAIL bp_first3: got %0d stalls required 0", tot); end
      fork
         begin
            send(0, 4'h0, 10'h014, 32'h0, 2'd3, s4, a4);
            send(0, 4'h0, 10'h015, 32'h0, 2'd0, s5, a5);
         end
         begin
            for (int k = 0; k < 3; k++) begin
               #4; vectors++;
               if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low: cycle %0d ready %b required 0", k, bus.req_ready_o); end
               @(negedge clk);
            end
            bus.resp_ready_i = 1;
            rel = cyc;
         end
      join
      vectors++;
      if (a4 != rel + 1) begin miscompares++; $display("FAIL bp_reaccept: 4th accepted cycle %0d required %0d", a4, rel + 1); end
      drain();
   endtask

   task automatic test_simultaneous();
      int s, c, tot = 0;
      bus.resp_ready_i = 0;
      send(0, 4'h0, 10'h016, 32'h0, 2'd1, s, c);
      send(0, 4'h0, 10'h017, 32'h0, 2'd2, s, c);
      @(negedge clk); #4; vectors++;
      if (bus.resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL sim_buffered: valid %b required 1", bus.resp_valid_o); end
      @(negedge clk);
      bus.resp_ready_i = 1;
      send(0, 4'h0, 10'h010, 32'h0, 2'd3, s, c); tot += s;
      send(0, 4'h0, 10'h012, 32'h0, 2'd0, s, c); tot += s;
      bus.resp_ready_i = 0;
      send(0, 4'h0, 10'h013, 32'h0, 2'd1, s, c); tot += s;
      #4; vectors += 2;
      if (tot != 0) begin miscompares++; $display("FAIL sim_stalls: got %0d required 0", tot); end
      if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL sim_credit_full: ready %b required 0", bus.req_ready_o); end
      @(negedge clk);
      drain();
   endtask

   task automatic test_reset_mid();
      int s, c;
      bus.resp_ready_i = 0;
      send(0, 4'h0, 10'h010, 32'h0, 2'd1, s, c);
      send(0, 4'h0, 10'h011, 32'h0, 2'd2, s, c);
      @(negedge clk); #4; vectors++;
      if (bus.resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL mid_buffered: valid %b required 1", bus.resp_valid_o); end
      @(negedge clk);
      rst = 1;
      #1; vectors += 2;
      if (bus.resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: valid %b required 0", bus.resp_valid_o); end
      if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready: ready %b required 0", bus.req_ready_o); end
      sb.delete(); pop_cyc.delete();
      @(negedge clk); rst = 0;
      #4; vectors += 2;
      if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready: ready %b required 1", bus.req_ready_o); end
      if (bus.resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_release_valid: valid %b required 0", bus.resp_valid_o); end
      @(negedge clk);
      bus.resp_ready_i = 1;
      repeat (5) @(negedge clk);
      vectors++;
      if (pop_cyc.size() != 0) begin miscompares++; $display("FAIL mid_stale: got %0d responses required 0", pop_cyc.size()); end
   endtask

`ifndef BANK_RESPONDER_WRITE_RESP_EN
   task automatic test_posted();
      int s, c, tot = 0;
      bus.resp_ready_i = 0;
      pop_cyc.delete();
      for (int i = 0; i < 4; i++) begin send(1, 4'hF, 10'h020 + 10'(i), 32'h1000 + i, 2'd3, s, c); tot += s; end
      send(0, 4'h0, 10'h022, 32'h0, 2'd0, s, c); tot += s;
      repeat (2) @(negedge clk);
      #4; vectors += 2;
      if (tot != 0) begin miscompares++; $display("FAIL posted_accept: got %0d stalls required 0", tot); end
      if (bus.resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL posted_valid: valid %b required 1", bus.resp_valid_o); end
      @(negedge clk);
      drain();
      repeat (3) @(negedge clk);
      vectors++;
      if (pop_cyc.size() != 1) begin miscompares++; $display("FAIL posted_count: got %0d responses required 1", pop_cyc.size()); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) begin sram[i] = '0; exp_mem[i] = '0; end
      bus.req_valid_i = 0; bus.req_wdata_i = '0; bus.req_ini_addr_i = 0; bus.resp_ready_i = 0;
      test_reset();
      test_read_after_write();
      test_stream();
      test_backpressure();
      test_simultaneous();
      test_reset_mid();
`ifndef BANK_RESPONDER_WRITE_RESP_EN
      test_posted();
`endif
      vectors++;
      if (sb.size() != 0) begin miscompares++; $display("FAIL final_scoreboard: %0d outstanding required 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/bank_responder.md
# bank_responder

Target-side endpoint for the variable-latency crossbar: consumes one crossbar target port (request valid/ready, initiator address, packed payload) and drives a fixed-latency single-port SRAM bank. Every response goes back on the crossbar response port, tagged with the originating initiator address. A credit counter bounds outstanding transactions so that responses are never dropped while the response port is backpressured.

## Interface
- NumIn, 4: initiators on the crossbar; IniW = $clog2(NumIn)
- AddrWidth, 10: bank word-address width
- DataWidth, 32: SRAM word width; BeW = DataWidth/8
- ReqDataWidth, 1+BeW+AddrWidth+DataWidth: packed request payload {wen, be, addr, wdata}, MSB first
- MemLatency, 1: SRAM read latency in cycles, ≥1
- FifoDepth, 3: response buffer entries and credits, ≥1; full throughput requires ≥MemLatency+2
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_ini_addr_i  in  IniW  initiator tag
- req_wdata_i  in  ReqDataWidth  packed payload
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response ready
- resp_ini_addr_o  out  IniW  tag of the response
- resp_rdata_o  out  DataWidth  read data; 0 for write responses
- mem_req_o, mem_we_o  out  1  SRAM strobe and write enable
- mem_be_o  out  BeW; mem_addr_o  out  AddrWidth; mem_wdata_o  out  DataWidth
- mem_rdata_i  in  DataWidth  valid MemLatency cycles after the strobe

## Operation
- Accept = req_valid_i & req_ready_o.
- req_ready_o = !rst_i & (credit_q < FifoDepth). It does not depend on resp_ready_i.
- On accept, mem_req_o is asserted the same cycle, and the payload fields drive the mem_* outputs combinationally. mem_req_o = 0 otherwise.
- Tag pipeline: MemLatency stages of {valid, is_write, ini_addr}, shifted every cycle and never stalled.
- When the last stage is valid, push {ini_addr, is_write ? 0 : mem_rdata_i} into the FIFO.
- FIFO is non-fall-through. Its head drives resp_*. Pop = resp_valid_o & resp_ready_i.
- credit_q: +1 on an accept that will produce a response, −1 on pop, unchanged when both occur. It can never exceed FifoDepth, so a push into a full FIFO is impossible; assert this.
- Responses are returned in acceptance order.
- Once resp_valid_o is asserted, resp_ini_addr_o and resp_rdata_o stay stable until popped.

## Timing
- Reset values: req_ready_o=0 while rst_i is high, 1 in the first cycle after release. resp_valid_o=0, resp_ini_addr_o=0, resp_rdata_o=0, mem_req_o=0, credit_q=0, all pipeline valids 0, FIFO empty with storage zeroed.
- Read accepted in cycle t: rdata is captured at the end of t+MemLatency, and resp_valid_o rises in t+MemLatency+1.
- Throughput is one request per cycle when FifoDepth ≥ MemLatency+2 and resp_ready_i is held high.
- Backpressure: with resp_ready_i low, exactly FifoDepth responding requests are accepted, then req_ready_o drops. req_ready_o rises the cycle after the first pop.
- Reset mid-operation clears all state. In-flight transactions are discarded; the initiators must be reset together with this block.

## Configuration
- BANK_RESPONDER_WRITE_RESP_EN defined: every write produces one response (rdata=0) and consumes a credit.
- Undefined: writes are posted.
  - A write takes no credit and is never pushed to the FIFO.
  - req_ready_o for writes still follows the credit rule.
  - Only reads return responses.

## Structure
- bank_responder_pkg holds:
  - the typedef of the request payload struct {wen, be, addr, wdata}
  - the typedef of the response entry struct {ini_addr, rdata}
  - width helper functions
- One sub-module, bank_resp_fifo: a parametric-depth FIFO with active-high asynchronous reset, non-fall-through, and full/empty/count outputs.
- The credit counter and tag pipeline live in bank_responder.

## Test plan
- Read after write (defaults, write response enabled):
  - Write addr 0x05 = 0xDEADBEEF with be=0xF, tag 2: response tag 2, rdata 0, valid 2 cycles after accept.
  - Then read 0x05 with tag 1: rdata 0xDEADBEEF, tag 1.
- Streaming: 8 back-to-back reads with resp_ready_i=1: req_ready_o never drops, 8 responses on consecutive cycles in order.
- Backpressure: resp_ready_i=0 and 5 read requests: 3 accepted, req_ready_o=0 from the 4th cycle on. Release ready: responses 1–3 in order, then the remaining 2 are accepted.
- Simultaneous accept and pop at credit_q=3−1: credit unchanged, no overflow, no lost response.
- Reset mid-stream: rst_i for 1 cycle with 2 responses buffered: resp_valid_o=0 immediately, no stale response afterwards, req_ready_o=1 after release.
- With BANK_RESPONDER_WRITE_RESP_EN undefined:
  - 4 writes then 1 read with resp_ready_i=0: all 5 accepted, a single response (the read) returned.
